timer_cmp_irq: RTL and testbench
================================

TIMER_CMP_IRQ -- requirements
Module: timer_cmp_irq

Interface
REQ-001 The module SHALL have these ports, one per line as: name, direction, width, meaning.
- sys_clk     in   1   system clock; all state updates on its rising edge.
- sys_rst_n   in   1   asynchronous active-low reset.
- count       in   64  live timer counter value, registered on sys_clk by the counter block.
- cnt_update  in   1   high in the cycle in which count holds a newly incremented value.
- halt_en     in   1   debug halt; freezes status set and auto-reload.
- wdata       in   32  register write data.
- cmp_wr_lo   in   1   load wdata into cmp_val[31:0].
- cmp_wr_hi   in   1   load wdata into cmp_val[63:32].
- prd_wr      in   1   load wdata into period.
- ctrl_wr     in   1   load wdata[0] into int_en and wdata[1] into auto_rld.
- st_clr      in   1   write-1-to-clear strobe: wdata[0] clears int_st, wdata[1] clears ovr_st.
- cmp_val     out  64  current compare value.
- period      out  32  auto-reload increment.
- int_en      out  1   interrupt enable.
- auto_rld    out  1   periodic-mode enable.
- int_st      out  1   sticky match status.
- ovr_st      out  1   sticky overrun status (match while int_st already set).
- tim_int     out  1   interrupt output.

Function
REQ-002 The block SHALL compute match = (count == cmp_val) combinationally, over the full 64 bits.
REQ-003 The block SHALL register match into match_q every cycle; match_q resets to 0.
REQ-004 The block SHALL generate match_evt = match & ~match_q & ~halt_en, so one event occurs per entry into equality.
REQ-005 A match that persists across cycles SHALL produce exactly one match_evt.
REQ-006 A match that arises from a cmp_val write (count static) SHALL also produce match_evt, one cycle after the write.
REQ-007 On match_evt, int_st SHALL be set to 1 on the next edge.
REQ-008 On match_evt while int_st is already 1, ovr_st SHALL be set to 1 on the next edge.
REQ-009 st_clr with wdata[0]=1 SHALL clear int_st, and st_clr with wdata[1]=1 SHALL clear ovr_st.
REQ-010 If a set and a clear hit the same flag in the same cycle, the set SHALL win.
REQ-011 tim_int SHALL be registered as int_st & int_en, giving one cycle of latency from the status or enable change.
REQ-012 Clearing int_en SHALL deassert tim_int without altering int_st.
REQ-013 In periodic mode (auto_rld=1, period!=0), on match_evt, cmp_val SHALL be loaded with cmp_val + {32'h0, period}, modulo 2^64 (wraps silently).
REQ-014 When period==0 or auto_rld==0, cmp_val SHALL be left unchanged on match_evt.
REQ-015 A cmp_wr_lo or cmp_wr_hi write SHALL have priority over auto-reload on the same half in the same cycle.
- Auto-reload still updates any half that is not being written.
- cmp_wr_lo and cmp_wr_hi together SHALL load wdata into both halves.
REQ-016 While halt_en=1, the block SHALL perform no status set and no auto-reload.
- match_q keeps tracking.
- Register writes and clears remain functional.
REQ-017 cnt_update SHALL be used only to qualify nothing beyond REQ-004; its presence is informational.
- It SHALL be reserved for a future one-shot mode.
- It SHALL NOT alter behaviour.

Reset
REQ-018 Asynchronous assertion of sys_rst_n=0 SHALL immediately force the following values, independent of sys_clk.
- cmp_val=64'hFFFF_FFFF_FFFF_FFFF, period=0.
- int_en=0, auto_rld=0.
- int_st=0, ovr_st=0, tim_int=0.
- match_q=0.
REQ-019 Reset deassertion mid-match SHALL produce a match_evt on the first clock if count==cmp_val, since match_q=0.

Verification
REQ-020 The bench SHALL cover a basic match: cmp_val=10, int_en=1, count ramps 0..15 -> int_st=1 at the edge after count==10, tim_int=1 one cycle later, and only one event.
REQ-021 The bench SHALL cover periodic mode: cmp_val=100, period=50, auto_rld=1 -> matches at count 100, 150, 200, with cmp_val reading 250 after the third.
REQ-022 The bench SHALL cover overrun and clear priority in two parts.
- Let two matches occur without a clear -> ovr_st=1.
- st_clr wdata=3 coinciding with match_evt -> int_st stays 1 and ovr_st stays 1.
REQ-023 The bench SHALL cover wrap: cmp_val=64'hFFFF_FFFF_FFFF_FFF0, period=32, match -> cmp_val=64'h10.
REQ-024 The bench SHALL cover halt: halt_en=1 while count passes cmp_val -> int_st stays 0 and cmp_val unchanged; after halt_en=0 with count still equal -> no event, since match_q=1.
REQ-025 The bench SHALL cover reset mid-operation: with int_st=1 and tim_int=1, pulse sys_rst_n low between clock edges -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/timer_cmp_irq.sv
// ============================================================================
// timer_cmp_irq : 64-bit compare with sticky status, overrun and auto-reload
// Revision      : 1.0
// ============================================================================
`default_nettype none

module timer_cmp_irq (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] count,
  input  logic        cnt_update,
  input  logic        halt_en,
  input  logic [31:0] wdata,
  input  logic        cmp_wr_lo,
  input  logic        cmp_wr_hi,
  input  logic        prd_wr,
  input  logic        ctrl_wr,
  input  logic        st_clr,
  output logic [63:0] cmp_val,
  output logic [31:0] period,
  output logic        int_en,
  output logic        auto_rld,
  output logic        int_st,
  output logic        ovr_st,
  output logic        tim_int
);

  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        match;
  logic        match_q;
  logic        match_evt;
  logic        do_reload;
  logic [63:0] reload_val;

  // Held for a future one-shot mode; it has no effect on behaviour today.
  logic        unused_cnt_update;
  assign unused_cnt_update = cnt_update;

  assign match      = (count == cmp_val);
  assign match_evt  = match & ~match_q & ~halt_en;
  assign reload_val = cmp_val + {32'h0, period};
  assign do_reload  = match_evt & auto_rld & (period != 32'h0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmp_val  <= CMP_RESET;
      period   <= 32'h0;
      int_en   <= 1'b0;
      auto_rld <= 1'b0;
      int_st   <= 1'b0;
      ovr_st   <= 1'b0;
      tim_int  <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      match_q <= match;

      // A register write on a half beats the reload of that same half.
      if (cmp_wr_lo)
        cmp_val[31:0] <= wdata;
      else if (do_reload)
        cmp_val[31:0] <= reload_val[31:0];

      if (cmp_wr_hi)
        cmp_val[63:32] <= wdata;
      else if (do_reload)
        cmp_val[63:32] <= reload_val[63:32];

      if (prd_wr)
        period <= wdata;

      if (ctrl_wr) begin
        int_en   <= wdata[0];
        auto_rld <= wdata[1];
      end

      // Set wins over a coincident clear.
      if (match_evt)
        int_st <= 1'b1;
      else if (st_clr && wdata[0])
        int_st <= 1'b0;

      if (match_evt && int_st)
        ovr_st <= 1'b1;
      else if (st_clr && wdata[1])
        ovr_st <= 1'b0;

      tim_int <= int_st & int_en;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_cmp_irq.sv
// Testbench for timer_cmp_irq: cycle model feeding an expected-value queue,
// plus directed scenario checks.
`default_nettype none

module tb_timer_cmp_irq;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] count = 64'h0;
  logic        cnt_update = 1'b0;
  logic        halt_en = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        cmp_wr_lo = 1'b0;
  logic        cmp_wr_hi = 1'b0;
  logic        prd_wr = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic        st_clr = 1'b0;
  logic [63:0] cmp_val;
  logic [31:0] period;
  logic        int_en;
  logic        auto_rld;
  logic        int_st;
  logic        ovr_st;
  logic        tim_int;

  timer_cmp_irq dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .count      (count),
    .cnt_update (cnt_update),
    .halt_en    (halt_en),
    .wdata      (wdata),
    .cmp_wr_lo  (cmp_wr_lo),
    .cmp_wr_hi  (cmp_wr_hi),
    .prd_wr     (prd_wr),
    .ctrl_wr    (ctrl_wr),
    .st_clr     (st_clr),
    .cmp_val    (cmp_val),
    .period     (period),
    .int_en     (int_en),
    .auto_rld   (auto_rld),
    .int_st     (int_st),
    .ovr_st     (ovr_st),
    .tim_int    (tim_int)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [63:0] cmp;
    logic [31:0] prd;
    logic        ie;
    logic        ar;
    logic        ist;
    logic        ost;
    logic        tint;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_cmp;
  logic [31:0] m_prd;
  logic        m_ie, m_ar, m_ist, m_ost, m_tint, m_mq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_prd = 32'h0;
    m_ie = 1'b0; m_ar = 1'b0; m_ist = 1'b0; m_ost = 1'b0; m_tint = 1'b0; m_mq = 1'b0;
  endtask

  // Next-state of the block from the inputs currently being driven.
  task automatic model_step();
    logic        hit, evt, rl;
    logic [63:0] sum, ncmp;
    hit  = (count == m_cmp);
    evt  = hit && !m_mq && !halt_en;
    sum  = m_cmp + {32'h0, m_prd};
    rl   = evt && m_ar && (m_prd != 0);
    ncmp = rl ? sum : m_cmp;
    if (cmp_wr_lo) ncmp[31:0]  = wdata;
    if (cmp_wr_hi) ncmp[63:32] = wdata;
    m_tint = m_ist && m_ie;
    if (evt && m_ist) m_ost = 1'b1;
    else if (st_clr && wdata[1]) m_ost = 1'b0;
    if (evt) m_ist = 1'b1;
    else if (st_clr && wdata[0]) m_ist = 1'b0;
    if (prd_wr) m_prd = wdata;
    if (ctrl_wr) begin
      m_ie = wdata[0];
      m_ar = wdata[1];
    end
    m_cmp = ncmp;
    m_mq  = hit;
  endtask

  task automatic tick();
    exp_t e;
    cnt_update = 1'($urandom_range(0, 1));
    model_step();
    e.cmp = m_cmp; e.prd = m_prd; e.ie = m_ie; e.ar = m_ar;
    e.ist = m_ist; e.ost = m_ost; e.tint = m_tint;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("cmp_val",  cmp_val,  e.cmp);
      check("period",   {32'h0, period}, {32'h0, e.prd});
      check("int_en",   {63'h0, int_en},   {63'h0, e.ie});
      check("auto_rld", {63'h0, auto_rld}, {63'h0, e.ar});
      check("int_st",   {63'h0, int_st},   {63'h0, e.ist});
      check("ovr_st",   {63'h0, ovr_st},   {63'h0, e.ost});
      check("tim_int",  {63'h0, tim_int},  {63'h0, e.tint});
    end
    cmp_wr_lo = 1'b0; cmp_wr_hi = 1'b0; prd_wr = 1'b0; ctrl_wr = 1'b0; st_clr = 1'b0;
  endtask

  task automatic wr_cmp(input logic [63:0] v);
    wdata = v[31:0];  cmp_wr_lo = 1'b1; tick();
    wdata = v[63:32]; cmp_wr_hi = 1'b1; tick();
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    wdata = v; ctrl_wr = 1'b1; tick();
  endtask

  task automatic wr_prd(input logic [31:0] v);
    wdata = v; prd_wr = 1'b1; tick();
  endtask

  task automatic clr(input logic [31:0] v);
    wdata = v; st_clr = 1'b1; tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmp"},  cmp_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_prd"},  {32'h0, period}, 64'h0);
    check({tag, "_ctl"},  {62'h0, int_en, auto_rld}, 64'h0);
    check({tag, "_st"},   {61'h0, int_st, ovr_st, tim_int}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_reset_values("reset");
    sys_rst_n = 1'b1;

    // Basic match at count 10, one event only.
    count = 64'd0;
    tick();
    wr_cmp(64'd10);
    wr_ctrl(32'h1);
    for (int c = 0; c <= 15; c++) begin
      count = 64'(c);
      tick();
      if (c == 10) begin
        check("basic_int_st", {63'h0, int_st}, 64'd1);
        check("basic_tint_lat", {63'h0, tim_int}, 64'd0);
      end
      if (c == 11) check("basic_tint", {63'h0, tim_int}, 64'd1);
    end
    check("basic_single_evt", {63'h0, ovr_st}, 64'd0);

    // Dropping int_en removes the interrupt but keeps the status.
    wr_ctrl(32'h0);
    tick();
    check("ie_off_tint", {63'h0, tim_int}, 64'd0);
    check("ie_off_ist",  {63'h0, int_st},  64'd1);

    // Periodic mode: 100, 150, 200 then 250.
    clr(32'h3);
    count = 64'd0;
    wr_prd(32'd50);
    wr_cmp(64'd100);
    wr_ctrl(32'h3);
    for (int c = 0; c <= 210; c++) begin
      count = 64'(c);
      tick();
      if (c == 100 || c == 150 || c == 200)
        check("periodic_reload", cmp_val, 64'(c + 50));
    end
    check("periodic_final", cmp_val, 64'd250);

    // Overrun, then set-beats-clear on both flags.
    wr_ctrl(32'h1);
    clr(32'h3);
    check("clr_both", {62'h0, int_st, ovr_st}, 64'd0);
    count = 64'd0;
    wr_cmp(64'd300);
    for (int c = 290; c <= 300; c++) begin count = 64'(c); tick(); end
    check("ovr_first", {62'h0, int_st, ovr_st}, 64'b10);
    count = 64'd301;
    wr_cmp(64'd305);
    for (int c = 302; c <= 305; c++) begin count = 64'(c); tick(); end
    check("ovr_second", {62'h0, int_st, ovr_st}, 64'b11);
    count = 64'd306;
    wr_cmp(64'd310);
    for (int c = 307; c <= 310; c++) begin
      count = 64'(c);
      if (c == 310) begin wdata = 32'h3; st_clr = 1'b1; end
      tick();
    end
    check("set_beats_clr", {62'h0, int_st, ovr_st}, 64'b11);

    // 64-bit wrap of the reload sum.
    clr(32'h3);
    wr_ctrl(32'h3);
    wr_prd(32'd32);
    count = 64'd0;
    wr_cmp(64'hFFFF_FFFF_FFFF_FFF0);
    count = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    check("wrap_cmp", cmp_val, 64'h10);

    // Halt suppresses status and reload; release while still equal gives no event.
    clr(32'h3);
    count = 64'd0;
    wr_cmp(64'd1000);
    halt_en = 1'b1;
    count = 64'd1000;
    tick();
    check("halt_ist", {63'h0, int_st}, 64'd0);
    check("halt_cmp", cmp_val, 64'd1000);
    halt_en = 1'b0;
    tick();
    check("unhalt_ist", {63'h0, int_st}, 64'd0);
    check("unhalt_cmp", cmp_val, 64'd1000);
    count = 64'd1001;
    tick();

    // Asynchronous reset between edges while the interrupt is active.
    wr_ctrl(32'h1);
    wr_cmp(64'd2000);
    count = 64'd2000;
    tick();
    tick();
    check("pre_rst_active", {62'h0, int_st, tim_int}, 64'b11);
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_rst");
    count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    sys_rst_n = 1'b1;
    tick();
    check("rst_release_match", {63'h0, int_st}, 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
